uart_rx_frame_engine: RTL and testbench

UART_RX_FRAME_ENGINE -- requirements
Module: uart_rx_frame_engine

---
 rtl/uart_rx_frame_engine.sv | 159 +++++++++++++++
 tb/tb_uart_rx_frame_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_engine.sv
// Oversampled UART receiver: 2-flop line synchroniser, 3-sample majority vote per bit,
// configurable 5..MAX_BITS data bits with optional parity, break detection and a valid/ready output register.
module uart_rx_frame_engine #(
    parameter int MAX_BITS   = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                pckl,
    input  logic                presetn,
    input  logic                baud_tick,
    input  logic                uartn_rxd,
    input  logic                loop,
    input  logic                loop_txd,
    input  logic                rx_enable,
    input  logic [3:0]          data_len,
    input  logic                pen,
    input  logic                eps,
    input  logic                sp,
    output logic [MAX_BITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_error,
    output logic                frame_error,
    output logic                break_det,
    output logic                overrun,
    output logic                rx_busy
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_A    = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_B    = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_C    = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    LEN_MAX = 4'(MAX_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;
    state_t state, state_nxt;

    logic                sync_p0, sync_p1, src, src_prev;
    logic [PW-1:0]       phase;
    logic [3:0]          bit_cnt, len_l;
    logic                pen_l, eps_l, sp_l;
    logic                samp_a, samp_b, any_one, perr_l;
    logic [MAX_BITS-1:0] shreg;
    logic                vote_now, vote, start_ok, frame_done, xfer;

    function automatic logic [3:0] clamp_len(input logic [3:0] v);
        if (v < 4'd5)    return 4'd5;
        if (v > LEN_MAX) return LEN_MAX;
        return v;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic par_exp(input logic s, input logic e, input logic [MAX_BITS-1:0] d);
        return s ? ~e : (e ? ^d : ~^d);
    endfunction

    // Line synchroniser; loop_txd is an internal, already-synchronous source.
    always_ff @(posedge pckl) begin
        if (!presetn) begin
            sync_p0  <= 1'b1;
            sync_p1  <= 1'b1;
            src_prev <= 1'b1;
        end else begin
            sync_p0  <= uartn_rxd;
            sync_p1  <= sync_p0;
            src_prev <= src;
        end
    end

    assign src      = loop ? loop_txd : sync_p1;
    assign vote_now = baud_tick && (phase == PH_C) && (state != IDLE);
    assign vote     = maj3(samp_a, samp_b, src);
    assign xfer     = rx_valid && rx_ready;

    always_ff @(posedge pckl) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rx_enable && src_prev && !src) state_nxt = START;
            START:   if (vote_now) state_nxt = vote ? IDLE : DATA;
            DATA:    if (vote_now && bit_cnt == len_l - 4'd1) state_nxt = pen_l ? PARITY : STOP;
            PARITY:  if (vote_now) state_nxt = STOP;
            STOP:    if (vote_now) state_nxt = (!any_one && !vote) ? BRKWAIT : IDLE;
            BRKWAIT: if (vote_now && vote) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rx_enable) state_nxt = IDLE;
    end

    always_comb begin
        rx_busy    = (state != IDLE);
        start_ok   = (state == START) && vote_now && !vote && rx_enable;
        frame_done = (state == STOP) && vote_now && rx_enable;
    end

    // Phase restarts at the detected falling edge; the bit count is bounded by the latched length.
    always_ff @(posedge pckl) begin
        if (!presetn || state == IDLE || state_nxt == IDLE) begin
            phase   <= '0;
            bit_cnt <= '0;
        end else begin
            if (baud_tick) phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            if (state == DATA && vote_now) bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge pckl) begin
        if (baud_tick && phase == PH_A) samp_a <= src;
        if (baud_tick && phase == PH_B) samp_b <= src;
        if (start_ok) begin
            len_l   <= clamp_len(data_len);
            pen_l   <= pen;
            eps_l   <= eps;
            sp_l    <= sp;
            shreg   <= '0;
            any_one <= 1'b0;
            perr_l  <= 1'b0;
        end
        if (state == DATA && vote_now) begin
            for (int i = 0; i < MAX_BITS; i++)
                if (bit_cnt == 4'(i)) shreg[i] <= vote;
            any_one <= any_one | vote;
        end
        if (state == PARITY && vote_now) begin
            perr_l  <= (vote != par_exp(sp_l, eps_l, shreg));
            any_one <= any_one | vote;
        end
    end

    // Output holding register: a frame completing against a stalled consumer is dropped.
    always_ff @(posedge pckl) begin
        if (!presetn) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_det    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data      <= shreg;
                rx_valid     <= 1'b1;
                parity_error <= perr_l;
                frame_error  <= !vote;
                break_det    <= !any_one && !vote;
            end else if (xfer) begin
                rx_valid <= 1'b0;
            end
            if (xfer)                                    overrun <= 1'b0;
            else if (frame_done && rx_valid && !rx_ready) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Bench for uart_rx_frame_engine: directed framing cases plus randomized frames checked
// against a transaction-level expectation queue built from the framing rules.
module tb_uart_rx_frame_engine;
    localparam int OS  = 16;
    localparam int LAT = 2 + 1 + 9 * OS + (OS / 2 + 1) + 1;

    logic       pckl = 1'b0;
    logic       presetn = 1'b0;
    logic       baud_tick = 1'b1;
    logic       uartn_rxd = 1'b1;
    logic       loop = 1'b0;
    logic       loop_txd = 1'b1;
    logic       rx_enable = 1'b1;
    logic [3:0] data_len = 4'd8;
    logic       pen = 1'b0, eps = 1'b0, sp = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b1;
    logic       parity_error, frame_error, break_det, overrun, rx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   use_loop = 1'b0;

    uart_rx_frame_engine #(.MAX_BITS(8), .OVERSAMPLE(OS)) dut (
        .pckl(pckl), .presetn(presetn), .baud_tick(baud_tick), .uartn_rxd(uartn_rxd),
        .loop(loop), .loop_txd(loop_txd), .rx_enable(rx_enable), .data_len(data_len),
        .pen(pen), .eps(eps), .sp(sp), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .parity_error(parity_error), .frame_error(frame_error),
        .break_det(break_det), .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 pckl = ~pckl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [7:0] d, input logic pe, input logic fe,
                                    input logic bd, input logic ov);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.bd = bd; e.ov = ov;
        return e;
    endfunction

    function automatic int model_len(input logic [3:0] dl);
        if (dl < 4'd5) return 5;
        if (dl > 4'd8) return 8;
        return int'(dl);
    endfunction

    function automatic logic model_parity(input logic [7:0] d, input logic e, input logic s);
        logic odd;
        odd = ($countones(d) % 2) == 1;
        if (s) return !e;
        return e ? odd : !odd;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pckl);
            #1;
        end
    endtask

    task automatic drive_line(input logic b);
        if (use_loop) loop_txd = b;
        else          uartn_rxd = b;
    endtask

    task automatic drive_bit(input logic b);
        drive_line(b);
        tick(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [3:0] dl, input logic p_en,
                              input logic e_ps, input logic s_p, input logic par,
                              input logic stp, input int gap, input bit lp);
        int len;
        use_loop = lp;
        loop     = lp;
        data_len = dl; pen = p_en; eps = e_ps; sp = s_p;
        len = model_len(dl);
        drive_bit(1'b0);
        for (int i = 0; i < len; i++) begin
            drive_bit(d[i]);
            if (i == 0) begin
                data_len = 4'($urandom); pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom);
            end
        end
        if (p_en) drive_bit(par);
        drive_bit(stp);
        drive_line(1'b1);
        tick(gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_parity_error"}, 32'(parity_error), 32'h0);
        check({tag, "_frame_error"}, 32'(frame_error), 32'h0);
        check({tag, "_break_det"}, 32'(break_det), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
        check({tag, "_rx_busy"}, 32'(rx_busy), 32'h0);
    endtask

    // Every cycle with rx_valid high is compared against the oldest outstanding frame.
    always @(negedge pckl) begin
        if (presetn === 1'b1 && rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rx_valid", 32'(rx_valid), 32'h0);
            end else begin
                check("rx_data", 32'(rx_data), 32'(exp_q[0].data));
                check("parity_error", 32'(parity_error), 32'(exp_q[0].pe));
                check("frame_error", 32'(frame_error), 32'(exp_q[0].fe));
                check("break_det", 32'(break_det), 32'(exp_q[0].bd));
                if (rx_ready === 1'b1) begin
                    check("overrun_at_transfer", 32'(overrun), 32'(exp_q[0].ov));
                    exp_q.delete(0);
                end
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        check_all_zero("reset");
        presetn = 1'b1;
        tick(20);

        // 8N1 0xA5 with exact output latency
        exp_q.push_back(mk_exp(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
        fork
            send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0);
            begin
                repeat (LAT - 1) @(posedge pckl);
                @(negedge pckl); check("a5_valid_early", 32'(rx_valid), 32'h0);
                @(negedge pckl); check("a5_valid_on_time", 32'(rx_valid), 32'h1);
                @(negedge pckl); check("a5_valid_one_cycle", 32'(rx_valid), 32'h0);
            end
        join

        // 7E1 0x35 with inverted parity, then stick parity (sp=1, eps=1 expects 0)
        exp_q.push_back(mk_exp(8'h35, 1'b1, 1'b0, 1'b0, 1'b0));
        send_frame(8'h35, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        exp_q.push_back(mk_exp(8'h35, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(8'h35, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8, 1'b0);

        // 4-cycle glitch on an idle line
        use_loop = 1'b0; loop = 1'b0; data_len = 4'd8; pen = 1'b0;
        drive_line(1'b0);
        tick(4);
        check("glitch_busy", 32'(rx_busy), 32'h1);
        drive_line(1'b1);
        tick(30);
        check("glitch_busy_clear", 32'(rx_busy), 32'h0);
        check("glitch_no_valid", 32'(rx_valid), 32'h0);

        // Break: line low for two 8N1 frame times
        exp_q.push_back(mk_exp(8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
        drive_line(1'b0);
        tick(2 * 10 * OS);
        check("break_wait_busy", 32'(rx_busy), 32'h1);
        check("break_frame_delivered", 32'(exp_q.size()), 32'h0);
        drive_line(1'b1);
        tick(40);
        check("break_released", 32'(rx_busy), 32'h0);

        // Overrun: two frames against a stalled consumer
        rx_ready = 1'b0;
        exp_q.push_back(mk_exp(8'h11, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        send_frame(8'h22, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20, 1'b0);
        check("ovr_held_data", 32'(rx_data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_valid_held", 32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_cleared", 32'(overrun), 32'h0);
        check("ovr_valid_cleared", 32'(rx_valid), 32'h0);

        // rx_enable drop mid-frame discards the partial frame
        data_len = 4'd8; pen = 1'b0;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        check("enable_busy_before", 32'(rx_busy), 32'h1);
        rx_enable = 1'b0;
        tick(1);
        check("enable_forces_idle", 32'(rx_busy), 32'h0);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
        drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
        drive_line(1'b1);
        tick(20);
        rx_enable = 1'b1;
        tick(4);
        check("enable_no_valid", 32'(rx_valid), 32'h0);

        // Reset during DATA, then a clean 0x5A
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
        presetn = 1'b0;
        drive_line(1'b1);
        tick(1);
        check_all_zero("midreset");
        presetn = 1'b1;
        tick(40);
        exp_q.push_back(mk_exp(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0);

        // Randomized frames against the framing model
        for (int f = 0; f < 40; f++) begin
            logic [7:0] d, dm;
            logic [3:0] dl;
            logic       p_en, e_ps, s_p, ep, par, stp;
            int         len, gap;
            bit         lp;
            dl   = 4'($urandom_range(0, 15));
            d    = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
            p_en = 1'($urandom); e_ps = 1'($urandom); s_p = 1'($urandom);
            stp  = ($urandom_range(0, 5) != 0);
            len  = model_len(dl);
            dm   = d & 8'((1 << len) - 1);
            ep   = model_parity(dm, e_ps, s_p);
            par  = ($urandom_range(0, 3) == 0) ? !ep : ep;
            gap  = stp ? int'($urandom_range(0, 20)) : 40 + int'($urandom_range(0, 10));
            lp   = ($urandom_range(0, 3) == 0);
            exp_q.push_back(mk_exp(dm, p_en && (par != ep), !stp,
                                   !stp && (dm == 8'h00) && (!p_en || !par), 1'b0));
            send_frame(d, dl, p_en, e_ps, s_p, par, stp, gap, lp);
        end

        use_loop = 1'b0; loop = 1'b0;
        tick(20);
        check("all_frames_delivered", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
